mix_columns_serial: RTL and testbench

- Downstream neighbour of the ShiftRows stage. Consumes the 128-bit ShiftRows state and applies AES MixColumns (FIPS-197 §5.1.3), one 32-bit column per clock.
- One column datapath is shared across four cycles to save area. Valid/ready handshakes on both sides.
- A per-block bypass input passes the state through unmodified for the final AES round, which has no MixColumns.

---
 rtl/mix_columns_serial.sv | 174 +++++++++++++++++
 tb/tb_mix_columns_serial.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_serial.sv
// ---------------------------------------------------------------------------
// mix_columns_serial
//
// AES MixColumns stage that follows ShiftRows. A single 32-bit column
// datapath is reused over four consecutive cycles to transform the whole
// 128-bit state. A per-block bypass skips the transform for the final round.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mix_in     128-bit state from ShiftRows (column c at [127-32c -: 32],
//              row 0 in the MSB byte of each column)
//   bypass     1 = pass the state through unchanged
//   in_valid   mix_in/bypass valid
//   in_ready   block can accept a new state this cycle
//   mix_out    resulting state, zero whenever out_valid is low
//   out_valid  mix_out valid
//   out_ready  downstream accepts mix_out
//   busy       high while columns are being transformed
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a block (in_ready high once out of reset)
// CALC  | transforming column col_cnt, one column per clock
// DONE  | result presented; new block may be accepted on the handshake
// ---------------------------------------------------------------------------
module mix_columns_serial (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] mix_in,
  input  logic         bypass,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] mix_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] data_q, data_d;
  logic         bypass_q, bypass_d;
  logic         live_q;
  logic         accept;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // live_q keeps in_ready low while in reset and for the edge that releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = live_q;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    col_in = data_q[127:96];
    case (col_cnt_q)
      2'd0: col_in = data_q[127:96];
      2'd1: col_in = data_q[95:64];
      2'd2: col_in = data_q[63:32];
      2'd3: col_in = data_q[31:0];
      default: col_in = data_q[127:96];
    endcase
  end

  assign col_out = mix_col(col_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      data_q    <= 128'h0;
      bypass_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      bypass_q  <= bypass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    bypass_d  = bypass_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d    = mix_in;
          bypass_d  = bypass;
          col_cnt_d = 2'd0;
          state_d   = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        // A bypassed block never reaches CALC; the guard keeps it untouched
        // should that ever change.
        if (!bypass_q) begin
          case (col_cnt_q)
            2'd0: data_d[127:96] = col_out;
            2'd1: data_d[95:64]  = col_out;
            2'd2: data_d[63:32]  = col_out;
            2'd3: data_d[31:0]   = col_out;
            default: data_d = data_q;
          endcase
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // accept already implies out_ready, so the output handshake and the
        // capture of the next block share this edge.
        if (accept) begin
          data_d    = mix_in;
          bypass_d  = bypass;
          col_cnt_d = 2'd0;
          state_d   = bypass ? DONE : CALC;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        col_cnt_d = 2'd0;
      end
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign mix_out   = (state_q == DONE) ? data_q : 128'h0;

endmodule

// File: tb/tb_mix_columns_serial.sv
module tb_mix_columns_serial;

  localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] T2_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] T2_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

  logic         clk;
  logic         rst_n;
  logic [127:0] mix_in;
  logic         bypass;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] mix_out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [127:0] sb[$];

  mix_columns_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mix_in    (mix_in),
    .bypass    (bypass),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mix_out   (mix_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every completed output handshake.
  initial begin
    logic [127:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %h want no output", mix_out);
        end else begin
          exp = sb.pop_front();
          if (mix_out !== exp) begin
            bad++;
            $display("FAIL sb_result: got %h want %h", mix_out, exp);
          end
        end
      end
    end
  end

  // Drives one block; returns just after the accepting edge.
  task automatic send(input logic [127:0] d, input logic b, input logic [127:0] e,
                      input bit push, output int waited);
    bit ok;
    mix_in   = d;
    bypass   = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    waited   = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 50 cycles");
    end else if (push) begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat = edges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat, output int bcnt);
    bit ok;
    ok   = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin
        ok  = 1'b1;
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL out_timeout: got out_valid=0 want 1 within 30 cycles");
    end
  endtask

  initial begin
    int lat, bcnt, waited;
    rst_n     = 1'b0;
    mix_in    = '0;
    bypass    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // 1: reset values, then one normal block
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mix_out", mix_out, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_at_release", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1'b1);

    send(T1_IN, 1'b0, T1_OUT, 1'b1, waited);
    wait_out(lat, bcnt);
    check("t1_latency", lat, 4);
    check("t1_busy_cycles", bcnt, 4);

    // 2: FIPS-197 round 1, issued while the previous result is handed off
    send(T2_IN, 1'b0, T2_OUT, 1'b1, waited);
    check("t2_accept_wait", waited, 0);
    wait_out(lat, bcnt);
    check("t2_latency", lat, 4);

    // 3: bypass, result visible in the cycle right after the accepting edge
    send(T2_IN, 1'b1, T2_IN, 1'b1, waited);
    wait_out(lat, bcnt);
    check("t3_latency", lat, 0);
    check("t3_busy_cycles", bcnt, 0);
    check("t3_busy_done", busy, 1'b0);
    @(posedge clk);
    #1;

    // 4: backpressure then back-to-back
    out_ready = 1'b0;
    send(T1_IN, 1'b0, T1_OUT, 1'b1, waited);
    wait_out(lat, bcnt);
    check("t4_latency", lat, 4);
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1;
      check("t4_stall_valid", out_valid, 1'b1);
      check("t4_stall_data", mix_out, T1_OUT);
      check("t4_stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send(T2_IN, 1'b0, T2_OUT, 1'b1, waited);
    check("t4_b2b_accept_wait", waited, 0);
    check("t4_b2b_busy", busy, 1'b1);
    wait_out(lat, bcnt);
    check("t4_b2b_latency", lat, 4);
    @(posedge clk);
    #1;

    // 5a: reset during the second CALC cycle
    send(T1_IN, 1'b0, T1_OUT, 1'b0, waited);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_mix_out", mix_out, 128'h0);
    check("t5_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(T1_IN, 1'b0, T1_OUT, 1'b1, waited);
    wait_out(lat, bcnt);
    check("t5_fresh_latency", lat, 4);
    check("t5_fresh_busy_cycles", bcnt, 4);
    @(posedge clk);
    #1;

    // 5b: reset while a result is stalled in DONE
    out_ready = 1'b0;
    send(T2_IN, 1'b0, T2_OUT, 1'b0, waited);
    wait_out(lat, bcnt);
    check("t5b_done_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5b_rst_valid", out_valid, 1'b0);
    check("t5b_rst_mix_out", mix_out, 128'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 6: input changes during CALC and DONE are ignored
    send(T2_IN, 1'b0, T2_OUT, 1'b1, waited);
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1;
      mix_in   = {$urandom, $urandom, $urandom, $urandom};
      bypass   = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mix_in    = {$urandom, $urandom, $urandom, $urandom};
    bypass    = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid", out_valid, 1'b1);
    for (int r = 0; r < 3; r++) begin
      mix_in = {$urandom, $urandom, $urandom, $urandom};
      bypass = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      check("t6_held_data", mix_out, T2_OUT);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("sb_leftover", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
